ex_pipe_shreg: RTL

EX_PIPE_SHREG -- requirements
Module: ex_pipe_shreg

---
 rtl/ex_pipe_shreg_pkg.sv | 32 +++
 rtl/ex_fwd_match.sv | 37 +++
 rtl/ex_pipe_shreg.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ex_pipe_shreg_pkg.sv
// Shared types and limits for the EX-stage shift-register pipe.
// Supplies default register-address and data widths when no shared defines are present.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ex_pipe_shreg_pkg;

  localparam int EX_SHREG_MAX_DEPTH = 8;
  localparam int REG_AW             = `REG_ADDR_WIDTH;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    CTL_RUN,
    CTL_HOLD,
    CTL_FLUSH,
    CTL_RESET
  } pipe_ctl_e;

  // Reset beats flush, flush beats stall.
  function automatic pipe_ctl_e decodeCtl(input logic rst, input logic flush, input logic stall);
    if (rst)   return CTL_RESET;
    if (flush) return CTL_FLUSH;
    if (stall) return CTL_HOLD;
    return CTL_RUN;
  endfunction

endpackage

// File: rtl/ex_fwd_match.sv
// Forwarding lookup across all pipe stages; the youngest (lowest index) matching stage wins.
module ex_fwd_match import ex_pipe_shreg_pkg::*; #(
  parameter int DEPTH = 1,
  parameter int FWD_W = 32
) (
  input  logic [DEPTH-1:0] stage_valid_i,
  input  logic [DEPTH-1:0] stage_regwrite_i,
  input  reg_addr_t        stage_rd_addr_i [DEPTH],
  input  logic [FWD_W-1:0] stage_data_i    [DEPTH],
  input  reg_addr_t        rs_addr_i,
  output logic             hit_o,
  output logic [FWD_W-1:0] data_o
);

  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match[k] = stage_valid_i[k] && stage_regwrite_i[k] &&
                 (stage_rd_addr_i[k] == rs_addr_i) && (rs_addr_i != '0);
    end
  end

  // Scan oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit_o  = 1'b1;
        data_o = stage_data_i[k];
      end
    end
  end

endmodule

// File: rtl/ex_pipe_shreg.sv
// DEPTH-stage EX pipe with stall/flush and a valid-stage counter.
// Forwarding ports and ex_fwd_match exist only when EX_PIPE_SHREG_FWD_EN is defined.
module ex_pipe_shreg import ex_pipe_shreg_pkg::*; #(
  parameter int DEPTH     = 1,
  parameter int PAYLOAD_W = 64,
  parameter int FWD_W     = 32,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  reg_addr_t            rd_addr_i,
  input  logic                 regwrite_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output reg_addr_t            rd_addr_o,
  output logic                 regwrite_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [CNT_W-1:0]     count_o
`ifdef EX_PIPE_SHREG_FWD_EN
  ,
  input  reg_addr_t            rs_addr_i,
  output logic                 fwd_hit_o,
  output logic [FWD_W-1:0]     fwd_data_o
`endif
);

  if (DEPTH < 1 || DEPTH > EX_SHREG_MAX_DEPTH) begin : g_depth_chk
    $error("ex_pipe_shreg: DEPTH out of range 1..EX_SHREG_MAX_DEPTH");
  end
  if (FWD_W > PAYLOAD_W) begin : g_fwd_w_chk
    $error("ex_pipe_shreg: FWD_W must not exceed PAYLOAD_W");
  end

  // Index k holds pipe stage k+1.
  logic [DEPTH-1:0]     valid_q,    valid_d;
  logic [DEPTH-1:0]     regwrite_q, regwrite_d;
  reg_addr_t            rdAddr_q  [DEPTH];
  reg_addr_t            rdAddr_d  [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [DEPTH];
  logic [CNT_W-1:0]     count_q,    count_d;
  pipe_ctl_e            ctl;

  assign ctl = decodeCtl(rst, flush_i, stall_i);

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rdAddr_d   = rdAddr_q;
    payload_d  = payload_q;
    count_d    = count_q;
    case (ctl)
      CTL_RUN: begin
        valid_d[0]    = valid_i;
        regwrite_d[0] = regwrite_i;
        rdAddr_d[0]   = rd_addr_i;
        payload_d[0]  = payload_i;
        for (int k = 1; k < DEPTH; k++) begin
          valid_d[k]    = valid_q[k-1];
          regwrite_d[k] = regwrite_q[k-1];
          rdAddr_d[k]   = rdAddr_q[k-1];
          payload_d[k]  = payload_q[k-1];
        end
        case ({valid_i, valid_q[DEPTH-1]})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
      CTL_FLUSH: begin
        valid_d = '0;
        count_d = '0;
      end
      CTL_RESET: begin
        valid_d    = '0;
        regwrite_d = '0;
        count_d    = '0;
        for (int k = 0; k < DEPTH; k++) begin
          rdAddr_d[k]  = '0;
          payload_d[k] = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    valid_q    <= valid_d;
    regwrite_q <= regwrite_d;
    rdAddr_q   <= rdAddr_d;
    payload_q  <= payload_d;
    count_q    <= count_d;
  end

  assign valid_o    = valid_q[DEPTH-1];
  assign regwrite_o = regwrite_q[DEPTH-1] & valid_q[DEPTH-1];
  assign rd_addr_o  = rdAddr_q[DEPTH-1];
  assign payload_o  = payload_q[DEPTH-1];
  assign count_o    = count_q;

`ifdef EX_PIPE_SHREG_FWD_EN
  logic [FWD_W-1:0] fwdSlice [DEPTH];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      fwdSlice[k] = payload_q[k][FWD_W-1:0];
    end
  end

  ex_fwd_match #(
    .DEPTH (DEPTH),
    .FWD_W (FWD_W)
  ) u_fwd_match (
    .stage_valid_i    (valid_q),
    .stage_regwrite_i (regwrite_q),
    .stage_rd_addr_i  (rdAddr_q),
    .stage_data_i     (fwdSlice),
    .rs_addr_i        (rs_addr_i),
    .hit_o            (fwd_hit_o),
    .data_o           (fwd_data_o)
  );
`endif

endmodule
